// File: rtl/vend_pkg.sv
// Shared types and constants for the vending command sequencer.
package vend_pkg;

    localparam int CREDIT_W = 7;
    typedef logic [CREDIT_W-1:0] credit_t;

    typedef enum logic [1:0] {
        IDLE,
        VEND,
        CHANGE
    } state_t;

    localparam logic [7:0] CMD_COIN_1 = 8'h31;
    localparam logic [7:0] CMD_COIN_5 = 8'h35;
    localparam logic [7:0] CMD_SEL_A  = 8'h41;
    localparam logic [7:0] CMD_SEL_D  = 8'h44;
    localparam logic [7:0] CMD_ABORT  = 8'h61;
    localparam logic [7:0] CMD_CANCEL = 8'h63;

    localparam int unsigned PRICE_0_DEF    = 5;
    localparam int unsigned PRICE_1_DEF    = 10;
    localparam int unsigned PRICE_2_DEF    = 15;
    localparam int unsigned PRICE_3_DEF    = 20;
    localparam int unsigned MAX_CREDIT_DEF = 99;

endpackage

// File: rtl/vend_interval_timer.sv
// Free-running interval counter: counts 0..LIMIT-1 while enabled, clear forces 0.
module vend_interval_timer #(
    parameter int          WIDTH = 32,
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WIDTH-1:0] count;

    assign tc = (count == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending session sequencer: decodes UART command bytes, keeps credit,
// and drives dispense / change / error pulses.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned CLK_FREQ          = 100_000_000,
    parameter int unsigned PRICE_0           = PRICE_0_DEF,
    parameter int unsigned PRICE_1           = PRICE_1_DEF,
    parameter int unsigned PRICE_2           = PRICE_2_DEF,
    parameter int unsigned PRICE_3           = PRICE_3_DEF,
    parameter int unsigned MAX_CREDIT        = MAX_CREDIT_DEF,
    parameter int unsigned COIN_PULSE_CYCLES = CLK_FREQ / 10,
    parameter int unsigned TIMEOUT_CYCLES    = CLK_FREQ * 30
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                vend_pulse,
    output logic [1:0]          vend_item,
    output logic                change_pulse,
    output logic                err_pulse
);

    state_t        state, state_next;
    credit_t       credit_next, coin_val, price;
    logic [7:0]    coin_sum;
    logic [1:0]    sel_idx, vend_item_next;
    logic          is_coin, is_sel, coin_ok, sel_ok;
    logic          chg_tc, idle_tc, idle_en, timeout;
    logic          busy_next, vend_next, change_next, err_next;

    vend_interval_timer #(.WIDTH(32), .LIMIT(COIN_PULSE_CYCLES)) u_change_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != CHANGE),
        .enable (state == CHANGE),
        .tc     (chg_tc)
    );

    // Idle timer only runs in IDLE with credit and a silent receiver.
    assign idle_en = (state == IDLE) && (credit != '0) && !rx_valid;
    assign timeout = idle_en && idle_tc;

    vend_interval_timer #(.WIDTH(32), .LIMIT(TIMEOUT_CYCLES)) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!idle_en),
        .enable (idle_en),
        .tc     (idle_tc)
    );

    always_comb begin
        is_coin  = (rx_data == CMD_COIN_1) || (rx_data == CMD_COIN_5);
        coin_val = (rx_data == CMD_COIN_5) ? credit_t'(5) : credit_t'(1);
        coin_sum = {1'b0, credit} + {1'b0, coin_val};
        coin_ok  = (coin_sum <= 8'(MAX_CREDIT));
        is_sel   = (rx_data >= CMD_SEL_A) && (rx_data <= CMD_SEL_D);
        sel_idx  = 2'(rx_data - CMD_SEL_A);
        case (sel_idx)
            2'd0:    price = credit_t'(PRICE_0);
            2'd1:    price = credit_t'(PRICE_1);
            2'd2:    price = credit_t'(PRICE_2);
            default: price = credit_t'(PRICE_3);
        endcase
        sel_ok = (credit >= price);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            credit       <= '0;
            busy         <= 1'b0;
            vend_pulse   <= 1'b0;
            vend_item    <= 2'd0;
            change_pulse <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            busy         <= busy_next;
            vend_pulse   <= vend_next;
            vend_item    <= vend_item_next;
            change_pulse <= change_next;
            err_pulse    <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        credit_next = credit;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (is_coin) begin
                        if (coin_ok) credit_next = coin_sum[CREDIT_W-1:0];
                    end else if (is_sel) begin
                        if (sel_ok) begin
                            state_next  = VEND;
                            credit_next = credit - price;
                        end
                    end else if (rx_data == CMD_CANCEL) begin
                        if (credit != '0) state_next = CHANGE;
                    end else if (rx_data == CMD_ABORT) begin
                        credit_next = '0;
                    end
                end else if (timeout) begin
                    state_next = CHANGE;
                end
            end
            VEND: state_next = (credit != '0) ? CHANGE : IDLE;
            CHANGE: begin
                // change_pulse marks the interval-start cycle; the unit leaves at its edge.
                if (change_pulse) begin
                    credit_next = credit - credit_t'(1);
                    if (credit == credit_t'(1)) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        err_next = 1'b0;
        if (rx_valid) begin
            if (state != IDLE)                err_next = 1'b1;
            else if (is_coin)                 err_next = !coin_ok;
            else if (is_sel)                  err_next = !sel_ok;
            else if (rx_data == CMD_CANCEL)   err_next = (credit == '0);
            else if (rx_data == CMD_ABORT)    err_next = 1'b0;
            else                              err_next = 1'b1;
        end
        vend_next      = (state == IDLE) && (state_next == VEND);
        vend_item_next = vend_next ? sel_idx : vend_item;
        change_next    = (state_next == CHANGE) && ((state != CHANGE) || chg_tc);
        busy_next      = (state_next != IDLE);
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Randomised and directed bench for vend_ctrl against a session-level credit model.
module tb_vend_ctrl;

    localparam int COIN = 4;
    localparam int TMO  = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [6:0] credit;
    logic       busy, vend_pulse, change_pulse, err_pulse;
    logic [1:0] vend_item;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc = 0;
    int mon_chg = 0, mon_vend = 0, mon_err = 0, mon_gap_err = 0;
    int last_chg = 0;
    bit in_run = 0;
    int price[4] = '{5, 10, 15, 20};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pulse counters, plus spacing of change pulses within one refund run.
    always @(negedge clk) begin
        if (change_pulse === 1'b1) begin
            mon_chg++;
            if (in_run && (cyc - last_chg) != COIN) mon_gap_err++;
            last_chg = cyc;
            in_run   = 1;
        end
        if (busy !== 1'b1) in_run = 0;
        if (vend_pulse === 1'b1) mon_vend++;
        if (err_pulse === 1'b1) mon_err++;
    end

    vend_ctrl #(.COIN_PULSE_CYCLES(COIN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .credit       (credit),
        .busy         (busy),
        .vend_pulse   (vend_pulse),
        .vend_item    (vend_item),
        .change_pulse (change_pulse),
        .err_pulse    (err_pulse)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(output int n, output bit to);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            step(1);
            n++;
        end
        to = (busy !== 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step(2);
        tests_run++; if (credit !== 7'd0) begin tests_failed++; $display("FAIL reset_credit got %0d want 0", credit); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (vend_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_vend got %b want 0", vend_pulse); end
        tests_run++; if (change_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_change got %b want 0", change_pulse); end
        tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err_pulse); end
        tests_run++; if (vend_item !== 2'd0) begin tests_failed++; $display("FAIL reset_item got %0d want 0", vend_item); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_exact_purchase;
        int v0, c0;
        send(8'h35);
        send(8'h35);
        tests_run++; if (credit !== 7'd10) begin tests_failed++; $display("FAIL exact_credit got %0d want 10", credit); end
        v0 = mon_vend; c0 = mon_chg;
        send("B");
        tests_run++; if (vend_pulse !== 1'b1 || vend_item !== 2'd1) begin tests_failed++; $display("FAIL exact_vend got pulse %b item %0d want 1 1", vend_pulse, vend_item); end
        tests_run++; if (credit !== 7'd0 || busy !== 1'b1) begin tests_failed++; $display("FAIL exact_after got credit %0d busy %b want 0 1", credit, busy); end
        step(1);
        tests_run++; if (busy !== 1'b0 || vend_pulse !== 1'b0) begin tests_failed++; $display("FAIL exact_done got busy %b vend %b want 0 0", busy, vend_pulse); end
        step(2);
        tests_run++; if (mon_vend - v0 != 1 || mon_chg - c0 != 0) begin tests_failed++; $display("FAIL exact_counts got vend %0d change %0d want 1 0", mon_vend - v0, mon_chg - c0); end
    endtask

    task automatic test_change;
        int c0, g0, n;
        bit to;
        repeat (3) send(8'h35);
        c0 = mon_chg; g0 = mon_gap_err;
        send("A");
        tests_run++; if (vend_pulse !== 1'b1 || vend_item !== 2'd0 || credit !== 7'd10) begin tests_failed++; $display("FAIL change_vend got pulse %b item %0d credit %0d want 1 0 10", vend_pulse, vend_item, credit); end
        wait_idle(n, to);
        tests_run++; if (to || n != 38) begin tests_failed++; $display("FAIL change_busy_cycles got %0d timeout %b want 38", n, to); end
        tests_run++; if (mon_chg - c0 != 10 || mon_gap_err != g0) begin tests_failed++; $display("FAIL change_pulses got %0d gap_err %0d want 10 0", mon_chg - c0, mon_gap_err - g0); end
        tests_run++; if (credit !== 7'd0) begin tests_failed++; $display("FAIL change_final got %0d want 0", credit); end
    endtask

    task automatic test_overflow;
        repeat (19) send(8'h35);
        send(8'h31);
        send(8'h31);
        tests_run++; if (credit !== 7'd97) begin tests_failed++; $display("FAIL ovf_setup got %0d want 97", credit); end
        send(8'h35);
        tests_run++; if (err_pulse !== 1'b1 || credit !== 7'd97) begin tests_failed++; $display("FAIL ovf_reject got err %b credit %0d want 1 97", err_pulse, credit); end
        send(8'h31);
        send(8'h31);
        tests_run++; if (err_pulse !== 1'b0 || credit !== 7'd99) begin tests_failed++; $display("FAIL ovf_ceiling got err %b credit %0d want 0 99", err_pulse, credit); end
        send(8'h31);
        tests_run++; if (err_pulse !== 1'b1 || credit !== 7'd99) begin tests_failed++; $display("FAIL ovf_full got err %b credit %0d want 1 99", err_pulse, credit); end
        send("a");
        repeat (3) send(8'h31);
        send("D");
        tests_run++; if (err_pulse !== 1'b1 || vend_pulse !== 1'b0 || credit !== 7'd3 || busy !== 1'b0) begin tests_failed++; $display("FAIL insufficient got err %b vend %b credit %0d busy %b want 1 0 3 0", err_pulse, vend_pulse, credit, busy); end
        send("a");
    endtask

    task automatic test_busy_drop;
        int c0, n;
        bit to;
        repeat (3) send(8'h31);
        c0 = mon_chg;
        send("c");
        tests_run++; if (busy !== 1'b1 || change_pulse !== 1'b1 || credit !== 7'd3) begin tests_failed++; $display("FAIL cancel_enter got busy %b chg %b credit %0d want 1 1 3", busy, change_pulse, credit); end
        step(1);
        send(8'h31);
        tests_run++; if (err_pulse !== 1'b1 || credit !== 7'd2) begin tests_failed++; $display("FAIL busy_drop got err %b credit %0d want 1 2", err_pulse, credit); end
        wait_idle(n, to);
        tests_run++; if (to || credit !== 7'd0 || mon_chg - c0 != 3) begin tests_failed++; $display("FAIL busy_refund got credit %0d pulses %0d timeout %b want 0 3", credit, mon_chg - c0, to); end
        send(8'h35); send(8'h31); send(8'h31);
        c0 = mon_chg;
        send("a");
        tests_run++; if (credit !== 7'd0 || err_pulse !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL abort got credit %0d err %b busy %b want 0 0 0", credit, err_pulse, busy); end
        step(8);
        tests_run++; if (mon_chg != c0) begin tests_failed++; $display("FAIL abort_no_change got %0d pulses want 0", mon_chg - c0); end
    endtask

    task automatic test_timeout;
        int c0, n;
        bit to;
        c0 = mon_chg;
        send(8'h31);
        step(TMO - 1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_early got busy %b want 0", busy); end
        step(1);
        tests_run++; if (busy !== 1'b1 || change_pulse !== 1'b1) begin tests_failed++; $display("FAIL timeout_fire got busy %b chg %b want 1 1", busy, change_pulse); end
        wait_idle(n, to);
        tests_run++; if (to || credit !== 7'd0 || mon_chg - c0 != 1) begin tests_failed++; $display("FAIL timeout_refund got credit %0d pulses %0d want 0 1", credit, mon_chg - c0); end
        c0 = mon_chg;
        send(8'h31);
        step(TMO - 1);
        send(8'h31);
        tests_run++; if (busy !== 1'b0 || credit !== 7'd2 || err_pulse !== 1'b0) begin tests_failed++; $display("FAIL timeout_race got busy %b credit %0d err %b want 0 2 0", busy, credit, err_pulse); end
        step(TMO - 1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_restart_early got busy %b want 0", busy); end
        step(1);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL timeout_restart_fire got busy %b want 1", busy); end
        wait_idle(n, to);
        tests_run++; if (to || mon_chg - c0 != 2) begin tests_failed++; $display("FAIL timeout_restart_refund got pulses %0d want 2", mon_chg - c0); end
    endtask

    task automatic test_reset_mid_change;
        int c0;
        send(8'h35); send(8'h31); send(8'h31);
        send("c");
        step(1);
        tests_run++; if (credit !== 7'd6 || busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_setup got credit %0d busy %b want 6 1", credit, busy); end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        tests_run++; if (credit !== 7'd0 || busy !== 1'b0 || change_pulse !== 1'b0 || vend_pulse !== 1'b0 || err_pulse !== 1'b0) begin tests_failed++; $display("FAIL rstmid got credit %0d busy %b chg %b vend %b err %b want all 0", credit, busy, change_pulse, vend_pulse, err_pulse); end
        c0 = mon_chg;
        step(12);
        tests_run++; if (mon_chg != c0 || credit !== 7'd0) begin tests_failed++; $display("FAIL rstmid_quiet got pulses %0d credit %0d want 0 0", mon_chg - c0, credit); end
    endtask

    task automatic test_random_sessions;
        int m, r, v, item, refund, exp_cycles, c0, vd0, n, exp_now;
        bit exp_err, exp_vend, exp_busy, to;
        logic [7:0] b;
        m = 0;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 99);
            exp_err = 0; exp_vend = 0; exp_busy = 0; refund = 0; item = 0; exp_cycles = 0;
            if (r < 55) begin
                b = (r < 35) ? 8'h35 : 8'h31;
                v = (r < 35) ? 5 : 1;
                if (m + v <= 99) m = m + v; else exp_err = 1;
                exp_now = m;
            end else if (r < 77) begin
                item = $urandom_range(0, 3);
                b = 8'(8'h41 + item);
                if (m >= price[item]) begin
                    m = m - price[item];
                    exp_vend = 1; exp_busy = 1; refund = m;
                    exp_cycles = 1 + ((refund > 0) ? (refund - 1) * COIN + 1 : 0);
                end else exp_err = 1;
                exp_now = m;
            end else if (r < 85) begin
                b = "c";
                exp_now = m;
                if (m > 0) begin
                    exp_busy = 1; refund = m; exp_cycles = (refund - 1) * COIN + 1;
                end else exp_err = 1;
            end else if (r < 90) begin
                b = "a"; m = 0; exp_now = 0;
            end else begin
                b = 8'($urandom_range(32, 48));
                exp_err = 1; exp_now = m;
            end
            c0 = mon_chg; vd0 = mon_vend;
            send(b);
            tests_run++; if (err_pulse !== exp_err || credit !== 7'(exp_now) || busy !== exp_busy) begin tests_failed++; $display("FAIL rand_%0d byte %h got err %b credit %0d busy %b want %b %0d %b", it, b, err_pulse, credit, busy, exp_err, exp_now, exp_busy); end
            if (exp_vend) begin
                tests_run++; if (vend_pulse !== 1'b1 || vend_item !== 2'(item)) begin tests_failed++; $display("FAIL rand_vend_%0d got pulse %b item %0d want 1 %0d", it, vend_pulse, vend_item, item); end
            end
            if (exp_busy) begin
                wait_idle(n, to);
                tests_run++; if (to || n != exp_cycles || mon_chg - c0 != refund || credit !== 7'd0) begin tests_failed++; $display("FAIL rand_session_%0d got cycles %0d pulses %0d credit %0d want %0d %0d 0", it, n, mon_chg - c0, credit, exp_cycles, refund); end
                m = 0;
            end
            step($urandom_range(0, 5));
            tests_run++; if (mon_vend - vd0 != (exp_vend ? 1 : 0)) begin tests_failed++; $display("FAIL rand_vend_count_%0d got %0d want %0d", it, mon_vend - vd0, exp_vend); end
        end
        send("a");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_exact_purchase;
        test_change;
        test_overflow;
        test_busy_drop;
        test_timeout;
        test_reset_mid_change;
        test_random_sessions;
        tests_run++; if (mon_gap_err != 0) begin tests_failed++; $display("FAIL change_spacing got %0d bad gaps want 0", mon_gap_err); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
